seq_detect_param: RTL and testbench

Parametrised serial sequence detector: the next generation of the lab's fixed-pattern Moore/Mealy detector FSM. It samples a 1-bit serial input X on a qualified clock edge and compares the last N sampled bits against a run-time-loadable N-bit pattern. It raises a registered one-cycle match pulse Z and keeps a saturating match count. It supports both overlapping and non-overlapping detection. It sits between a serial bit source, such as a stimulus or deserialiser, and downstream logic that consumes match events.

---
 rtl/seq_detect_param.sv | 97 +++++++++
 tb/tb_seq_detect_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector: compares the last N qualified bits of X against a
// loadable pattern, with overlap/non-overlap modes and a saturating match count.
module seq_detect_param #(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             X,
  input  logic             en,
  input  logic             load,
  input  logic [N-1:0]     pattern,
  input  logic             ovl,
  output logic             Z,
  output logic [CNT_W-1:0] match_count,
  output logic             sat,
  output logic             armed
);

  // state | meaning
  // IDLE  | no pattern loaded since reset; X ignored
  // FILL  | fewer than N qualified bits collected in hist
  // ARMED | hist holds N qualified bits

  localparam int                FW        = $clog2(N + 1);
  localparam logic [FW-1:0]     FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   pat_r;
  logic [N-1:0]   hist;
  logic [N-1:0]   next_hist;
  logic           ovl_r;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  next_fill;
  logic           hit;

  always_comb begin
    next_hist = {hist[N-2:0], X};
    next_fill = (fill == FILL_FULL) ? fill : fill + FW'(1);
    hit       = (next_fill == FILL_FULL) && (next_hist == pat_r);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      pat_r       <= '0;
      ovl_r       <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      Z           <= 1'b0;
      match_count <= '0;
      sat         <= 1'b0;
      armed       <= 1'b0;
      state       <= IDLE;
    end else if (load) begin
      pat_r       <= pattern;
      ovl_r       <= ovl;
      hist        <= '0;
      fill        <= '0;
      Z           <= 1'b0;
      match_count <= '0;
      sat         <= 1'b0;
      armed       <= 1'b1;
      state       <= FILL;
    end else if (en && (state != IDLE)) begin
      if (hit) begin
        Z <= 1'b1;
        if (match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
        else                        sat         <= 1'b1;
        // Non-overlap mode restarts collection so no bit is shared between matches
        if (ovl_r) begin
          hist  <= next_hist;
          fill  <= next_fill;
          state <= ARMED;
        end else begin
          hist  <= '0;
          fill  <= '0;
          state <= FILL;
        end
      end else begin
        Z     <= 1'b0;
        hist  <= next_hist;
        fill  <= next_fill;
        state <= (next_fill == FILL_FULL) ? ARMED : FILL;
      end
    end else begin
      Z <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (N=3/CNT_W=8 and N=2/CNT_W=2) share
// stimulus and are compared each cycle against a queue-based reference model.
module tb_seq_detect_param;

  logic       Clk = 1'b0;
  logic       reset, X, en, load, ovl;
  logic [2:0] pattern;

  logic       z0, sat0, armed0;
  logic [7:0] cnt0;
  logic       z1, sat1, armed1;
  logic [1:0] cnt1;

  int checks   = 0;
  int failures = 0;
  int zc0, zc1;

  always #5 Clk = ~Clk;

  seq_detect_param #(.N(3), .CNT_W(8)) dut (
    .Clk(Clk), .reset(reset), .X(X), .en(en), .load(load),
    .pattern(pattern), .ovl(ovl),
    .Z(z0), .match_count(cnt0), .sat(sat0), .armed(armed0)
  );

  seq_detect_param #(.N(2), .CNT_W(2)) dut2 (
    .Clk(Clk), .reset(reset), .X(X), .en(en), .load(load),
    .pattern(pattern[1:0]), .ovl(ovl),
    .Z(z1), .match_count(cnt1), .sat(sat1), .armed(armed1)
  );

  // reference model: list of qualified bits since last clear, oldest first
  bit q0[$];
  bit q1[$];
  int m_n[2]   = '{3, 2};
  int m_max[2] = '{255, 3};
  int m_pat[2], m_ovl[2], e_z[2], e_cnt[2], e_sat[2], e_armed[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit tail_match(input bit q[$], input int n, input int p);
    if (q.size() != n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (q[i] != ((p >> (n - 1 - i)) & 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int d, input bit r, input bit ld, input bit e,
                            input bit x, input int p, input bit ov);
    bit q[$];
    if (d == 0) q = q0; else q = q1;
    if (r) begin
      e_armed[d] = 0; m_pat[d] = 0; m_ovl[d] = 0; q.delete();
      e_cnt[d] = 0; e_sat[d] = 0; e_z[d] = 0;
    end else if (ld) begin
      e_armed[d] = 1; m_pat[d] = p % (1 << m_n[d]); m_ovl[d] = ov; q.delete();
      e_cnt[d] = 0; e_sat[d] = 0; e_z[d] = 0;
    end else if (e && e_armed[d] == 1) begin
      q.push_back(x);
      if (q.size() > m_n[d]) void'(q.pop_front());
      e_z[d] = tail_match(q, m_n[d], m_pat[d]);
      if (e_z[d] == 1) begin
        if (e_cnt[d] < m_max[d]) e_cnt[d]++;
        else e_sat[d] = 1;
        if (m_ovl[d] == 0) q.delete();
      end
    end else begin
      e_z[d] = 0;
    end
    if (d == 0) q0 = q; else q1 = q;
  endtask

  task automatic step(input bit r, input bit ld, input bit e, input bit x,
                      input logic [2:0] p, input bit ov);
    @(negedge Clk);
    reset = r; load = ld; en = e; X = x; pattern = p; ovl = ov;
    @(posedge Clk);
    model_step(0, r, ld, e, x, int'(p), ov);
    model_step(1, r, ld, e, x, int'(p), ov);
    #1;
    if (z0) zc0++;
    if (z1) zc1++;
    check("z_n3",      z0,     e_z[0]);
    check("count_n3",  cnt0,   e_cnt[0]);
    check("sat_n3",    sat0,   e_sat[0]);
    check("armed_n3",  armed0, e_armed[0]);
    check("z_n2",      z1,     e_z[1]);
    check("count_n2",  cnt1,   e_cnt[1]);
    check("sat_n2",    sat1,   e_sat[1]);
    check("armed_n2",  armed1, e_armed[1]);
  endtask

  task automatic bits(input logic [15:0] seq, input int len, input logic [2:0] p, input bit ov);
    for (int i = len - 1; i >= 0; i--) step(0, 0, 1, seq[i], p, ov);
  endtask

  initial begin
    reset = 1; load = 0; en = 0; X = 0; pattern = 0; ovl = 0;

    // reset then stream with no load: detector must stay idle
    step(1, 0, 0, 0, 3'b000, 0);
    step(1, 0, 0, 0, 3'b000, 0);
    zc0 = 0; zc1 = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 1, i[0], 3'b000, 0);
    check("idle_zcount", zc0 + zc1, 0);
    check("idle_armed", armed0, 0);

    // basic detection, pattern 110 non-overlap
    step(0, 1, 0, 0, 3'b110, 0);
    zc0 = 0;
    bits(16'b1010110110110, 13, 3'b110, 0);
    check("basic_zcount", zc0, 3);
    check("basic_count", cnt0, 3);

    // overlap vs non-overlap, pattern 101
    step(0, 1, 0, 0, 3'b101, 1);
    zc0 = 0;
    bits(16'b10101, 5, 3'b101, 1);
    check("ovl_zcount", zc0, 2);
    check("ovl_count", cnt0, 2);
    step(0, 1, 0, 0, 3'b101, 0);
    zc0 = 0;
    bits(16'b10101, 5, 3'b101, 0);
    check("novl_zcount", zc0, 1);
    check("novl_count", cnt0, 1);

    // en gaps do not break a sequence
    step(0, 1, 0, 0, 3'b110, 0);
    zc0 = 0;
    step(0, 0, 1, 1, 3'b110, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'b110, 0);
    step(0, 0, 1, 1, 3'b110, 0);
    step(0, 0, 1, 0, 3'b110, 0);
    check("gap_zcount", zc0, 1);
    check("gap_z_last", z0, 1);

    // saturation on the 2-bit-counter instance, pattern 11 overlap
    step(0, 1, 0, 0, 3'b011, 1);
    zc1 = 0;
    bits(16'b111111, 6, 3'b011, 1);
    check("sat_zcount", zc1, 5);
    check("sat_count", cnt1, 3);
    check("sat_flag", sat1, 1);
    step(0, 1, 0, 0, 3'b011, 1);
    check("sat_clear_count", cnt1, 0);
    check("sat_clear_flag", sat1, 0);

    // load mid-stream discards the match in progress
    step(0, 1, 0, 0, 3'b110, 0);
    bits(16'b11, 2, 3'b110, 0);
    zc0 = 0;
    step(0, 1, 1, 0, 3'b110, 0);
    check("midload_z", z0, 0);
    bits(16'b110, 3, 3'b110, 0);
    check("midload_zcount", zc0, 1);

    // reset mid-stream: disarmed, nothing detected afterwards
    bits(16'b11, 2, 3'b110, 0);
    zc0 = 0;
    step(1, 0, 1, 0, 3'b110, 0);
    bits(16'b110, 3, 3'b110, 0);
    check("midrst_zcount", zc0, 0);
    check("midrst_armed", armed0, 0);

    // randomized traffic against the model
    step(0, 1, 0, 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
